// File: rtl/synth_pkg.sv
// synth_pkg: shared voice count, parser states, MIDI status nibbles and the Q22.10 note frequency table.
package synth_pkg;
  localparam int NUM_VOICES = 8;
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON = 4'h9;
  localparam logic [3:0] ST_CTRL = 4'hB;
  typedef enum logic [1:0] {IDLE, WAIT_NOTE, WAIT_VEL, APPLY} parser_state_t;
  typedef logic [0:127][31:0] freq_table_t;
  // octave 4 (notes 60..71) in units of 1e-7 Hz; other octaves derived by exact shifts
  localparam logic [0:11][35:0] SEMITONE = '{
    36'd2616255653, 36'd2771826310, 36'd2936647679, 36'd3111269837,
    36'd3296275569, 36'd3492282314, 36'd3699944227, 36'd3919954360,
    36'd4153046976, 36'd4400000000, 36'd4661637615, 36'd4938833013};
  function automatic logic [31:0] note_freq(input int n);
    logic [63:0] num = 64'(SEMITONE[n % 12]) * 64'd1024;
    logic [63:0] den = 64'd10000000;
    int oct = n / 12 - 5;
    if (oct >= 0) num = num << oct;
    else den = den << -oct;
    return 32'((num + den / 2) / den);
  endfunction
  function automatic freq_table_t build_note_freq();
    freq_table_t t;
    for (int i = 0; i < 128; i++) t[i] = note_freq(i);
    return t;
  endfunction
  localparam freq_table_t NOTE_FREQ = build_note_freq();
endpackage

// File: rtl/midi_voice_controller_if.sv
// midi_voice_controller_if: valid/ready byte stream carrying received MIDI bytes.
interface midi_voice_controller_if;
  logic [7:0] midi_byte;
  logic midi_valid;
  logic midi_ready;
  modport master(output midi_byte, midi_valid, input midi_ready);
  modport slave(input midi_byte, midi_valid, output midi_ready);
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: picks the voice for a note: matching active voice, else lowest free, else steal_ptr.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  localparam int IW = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]      active,
  input  logic [NUM_VOICES-1:0][6:0] notes,
  input  logic [6:0]                 note,
  input  logic [IW-1:0]              steal_ptr,
  output logic [IW-1:0]              idx,
  output logic                       hit
);
  logic free;
  logic [IW-1:0] match_idx, free_idx;
  // scanning downward leaves the lowest qualifying index in each result
  always_comb begin
    hit = 1'b0;
    free = 1'b0;
    match_idx = '0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && notes[i] == note) begin
        hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!active[i]) begin
        free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end
  assign idx = hit ? match_idx : free ? free_idx : steal_ptr;
endmodule

// File: rtl/midi_voice_controller.sv
// midi_voice_controller: parses MIDI note-on/off into per-voice pitch, gain and active flags.
// Define SUSTAIN_PEDAL_EN to add the CC64 sustain pedal.
module midi_voice_controller import synth_pkg::*; #(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter int NUM_VOICES = synth_pkg::NUM_VOICES
) (
  input  logic                        clk,
  input  logic                        reset_n,
  midi_voice_controller_if.slave      midi,
  output logic [NUM_VOICES-1:0][31:0] frequencies,
  output logic [NUM_VOICES-1:0][31:0] voice_volumes,
  output logic [NUM_VOICES-1:0]       voice_active
);
  localparam int IW = $clog2(NUM_VOICES);
  parser_state_t state, state_next;
  logic [3:0] cmd, cmd_next, hi;
  logic [6:0] note, note_next, vel, vel_next;
  logic ready_en, accept, cmd_ok, apply, note_on, note_off, hit, sustain, release_all;
  logic [IW-1:0] steal_ptr, idx;
  logic [NUM_VOICES-1:0][6:0] voice_note;
  logic [NUM_VOICES-1:0] sustained;
  assign hi = midi.midi_byte[7:4];
  assign midi.midi_ready = ready_en && state != APPLY;
  assign accept = midi.midi_valid && midi.midi_ready;
  assign apply = state == APPLY;
  assign note_on = apply && cmd == ST_NOTE_ON && vel != '0;
  assign note_off = apply && (cmd == ST_NOTE_OFF || (cmd == ST_NOTE_ON && vel == '0));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cmd <= '0;
      note <= '0;
      vel <= '0;
      ready_en <= 1'b0;
    end else begin
      state <= state_next;
      cmd <= cmd_next;
      note <= note_next;
      vel <= vel_next;
      ready_en <= 1'b1;
    end
  // realtime bytes (F8-FF) fall through untouched; IDLE means no running status
  always_comb begin
    state_next = state;
    cmd_next = cmd;
    note_next = note;
    vel_next = vel;
    if (apply) state_next = WAIT_NOTE;
    else if (accept && midi.midi_byte < 8'hF8) begin
      if (midi.midi_byte[7]) begin
        state_next = (midi.midi_byte[3:0] == MIDI_CHANNEL && cmd_ok) ? WAIT_NOTE : IDLE;
        cmd_next = hi;
      end else if (state == WAIT_NOTE) begin
        note_next = midi.midi_byte[6:0];
        state_next = WAIT_VEL;
      end else if (state == WAIT_VEL) begin
        vel_next = midi.midi_byte[6:0];
        state_next = APPLY;
      end
    end
  end
  voice_allocator #(.NUM_VOICES(NUM_VOICES)) u_alloc (
    .active(voice_active), .notes(voice_note), .note(note),
    .steal_ptr(steal_ptr), .idx(idx), .hit(hit)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      frequencies <= '0;
      voice_volumes <= '0;
      voice_active <= '0;
      voice_note <= '0;
      steal_ptr <= '0;
    end else if (note_on) begin
      frequencies[idx] <= NOTE_FREQ[note];
      voice_volumes[idx] <= 32'(vel) << 9;
      voice_active[idx] <= 1'b1;
      voice_note[idx] <= note;
      if (!hit && &voice_active) steal_ptr <= steal_ptr + 1'b1;
    end else if (note_off && hit && !sustain) begin
      voice_active[idx] <= 1'b0;
      voice_volumes[idx] <= '0;
    end else if (release_all) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (sustained[i]) begin
          voice_active[i] <= 1'b0;
          voice_volumes[i] <= '0;
        end
    end
`ifdef SUSTAIN_PEDAL_EN
  logic pedal;
  assign cmd_ok = hi == ST_NOTE_ON || hi == ST_NOTE_OFF || hi == ST_CTRL;
  assign pedal = apply && cmd == ST_CTRL && note == 7'h40;
  assign release_all = pedal && !vel[6];
  // held notes stay sounding until the pedal lifts; a fresh note-on unmarks its voice
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sustain <= 1'b0;
      sustained <= '0;
    end else if (pedal) begin
      sustain <= vel[6];
      if (!vel[6]) sustained <= '0;
    end else if (note_on) sustained[idx] <= 1'b0;
    else if (note_off && hit && sustain) sustained[idx] <= 1'b1;
`else
  assign cmd_ok = hi == ST_NOTE_ON || hi == ST_NOTE_OFF;
  assign sustain = 1'b0;
  assign sustained = '0;
  assign release_all = 1'b0;
`endif
endmodule

// File: tb/tb_midi_voice_controller.sv
// tb_midi_voice_controller: directed MIDI byte streams checked against a message-level voice model.
module tb_midi_voice_controller;
`ifdef SUSTAIN_PEDAL_EN
  localparam bit SUS = 1'b1;
`else
  localparam bit SUS = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0][31:0] frequencies, voice_volumes;
  logic [7:0] voice_active;
  int errors = 0, checks = 0;
  midi_voice_controller_if bus();
  midi_voice_controller #(.MIDI_CHANNEL(4'd0), .NUM_VOICES(8)) dut (
    .clk(clk), .reset_n(reset_n), .midi(bus),
    .frequencies(frequencies), .voice_volumes(voice_volumes), .voice_active(voice_active)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction
  function automatic int nf(input int n);
    return $rtoi(440.0 * 2.0 ** ((n - 69) / 12.0) * 1024.0 + 0.5);
  endfunction
  // message-level model: voices as arrays, bytes assembled per running status
  int m_freq[8], m_vol[8], m_note[8];
  bit m_act[8], m_susd[8];
  bit m_sus, exp_ready, pend;
  int m_ptr, m_rs, m_cnt, m_d1, p_rs, p_d1, p_d2;
  function automatic void apply_event(input int rs, input int n, input int v);
    int m = -1, f = -1, t;
    for (int i = 0; i < 8; i++) begin
      if (m < 0 && m_act[i] && m_note[i] == n) m = i;
      if (f < 0 && !m_act[i]) f = i;
    end
    if (rs == 11) begin
      if (n == 64) begin
        m_sus = v >= 64;
        if (v < 64)
          for (int i = 0; i < 8; i++)
            if (m_susd[i]) begin m_act[i] = 0; m_vol[i] = 0; m_susd[i] = 0; end
      end
    end else if (rs == 9 && v > 0) begin
      t = m >= 0 ? m : f >= 0 ? f : m_ptr;
      if (m < 0 && f < 0) m_ptr = (m_ptr + 1) % 8;
      m_freq[t] = nf(n); m_vol[t] = v * 512; m_act[t] = 1; m_note[t] = n; m_susd[t] = 0;
    end else if (m >= 0) begin
      if (m_sus) m_susd[m] = 1;
      else begin m_act[m] = 0; m_vol[m] = 0; end
    end
  endfunction
  function automatic void parse(input logic [7:0] b);
    int h = int'(b[7:4]);
    if (b >= 8'hF8) return;
    if (b[7]) begin
      if (b[3:0] == 4'd0 && (h == 8 || h == 9 || (SUS && h == 11))) begin m_rs = h; m_cnt = 0; end
      else m_rs = 0;
    end else if (m_rs != 0) begin
      if (m_cnt == 0) begin m_d1 = int'(b); m_cnt = 1; end
      else begin p_rs = m_rs; p_d1 = m_d1; p_d2 = int'(b); pend = 1; m_cnt = 0; end
    end
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        m_freq[i] = 0; m_vol[i] = 0; m_note[i] = 0; m_act[i] = 0; m_susd[i] = 0;
      end
      m_sus = 0; m_ptr = 0; m_rs = 0; m_cnt = 0; pend = 0; exp_ready = 0;
    end else begin
      if (pend) begin apply_event(p_rs, p_d1, p_d2); pend = 0; end
      else if (exp_ready && bus.midi_valid) parse(bus.midi_byte);
      exp_ready = !pend;
    end
  always @(negedge clk)
    if (reset_n) begin
      logic [7:0] ea;
      for (int i = 0; i < 8; i++) ea[i] = m_act[i];
      chk("midi_ready", bus.midi_ready, exp_ready);
      chk("voice_active", voice_active, ea);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("freq[%0d]", i), frequencies[i], m_freq[i]);
        chk($sformatf("vol[%0d]", i), voice_volumes[i], m_vol[i]);
      end
    end
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    bus.midi_byte = b;
    bus.midi_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.midi_ready;
      @(posedge clk);
    end
    #1 bus.midi_valid = 1'b0;
    chk($sformatf("handshake 0x%0h", b), ok, 1);
  endtask
  task automatic sendv(input logic [7:0] b[$]);
    foreach (b[i]) send(b[i]);
  endtask
  task automatic settle();
    repeat (3) @(negedge clk);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    bus.midi_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ready", bus.midi_ready, 0);
    chk("reset active", voice_active, 0);
    chk("reset freq0", frequencies[0], 0);
    chk("reset vol7", voice_volumes[7], 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.midi_byte = 8'h00;
    bus.midi_valid = 1'b0;
    do_reset();
    chk("ready after reset", bus.midi_ready, 1);
    // single note-on
    sendv('{8'h90, 8'h45, 8'h64});
    settle();
    chk("on freq0", frequencies[0], 450560);
    chk("on vol0", voice_volumes[0], 51200);
    chk("on active", voice_active, 8'h01);
    // realtime byte mid-message
    do_reset();
    sendv('{8'h90, 8'h45, 8'hF8, 8'h64});
    settle();
    chk("rt freq0", frequencies[0], 450560);
    chk("rt vol0", voice_volumes[0], 51200);
    chk("rt active", voice_active, 8'h01);
    // reset pulse mid-message discards the partial note
    do_reset();
    sendv('{8'h90, 8'h45});
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(8'h64);
    settle();
    chk("rstmid active", voice_active, 0);
    chk("rstmid freq0", frequencies[0], 0);
    chk("rstmid vol0", voice_volumes[0], 0);
    // running status, release, retrigger, unmatched note-off
    do_reset();
    sendv('{8'h90, 8'h3C, 8'h40, 8'h40, 8'h50});
    settle();
    chk("rs freq0", frequencies[0], 267905);
    chk("rs freq1", frequencies[1], 337539);
    chk("rs vol1", voice_volumes[1], 40960);
    chk("rs active", voice_active, 8'h03);
    sendv('{8'h90, 8'h3C, 8'h00});
    settle();
    chk("rel active", voice_active, 8'h02);
    chk("rel vol0", voice_volumes[0], 0);
    chk("rel freq0 held", frequencies[0], 267905);
    sendv('{8'h90, 8'h40, 8'h7F});
    settle();
    chk("retrig vol1", voice_volumes[1], 65024);
    chk("retrig active", voice_active, 8'h02);
    sendv('{8'h80, 8'h50, 8'h10, 8'h40, 8'h10});
    settle();
    chk("off active", voice_active, 8'h00);
    // other channel and stray data bytes are dropped
    sendv('{8'h91, 8'h45, 8'h64, 8'hF0, 8'h45, 8'h64});
    settle();
    chk("foreign active", voice_active, 8'h00);
    // nine distinct notes steal voice 0, tenth lands on voice 1
    do_reset();
    send(8'h90);
    for (int n = 60; n <= 68; n++) sendv('{8'(n), 8'h64});
    settle();
    chk("steal freq0", frequencies[0], 425272);
    chk("steal active", voice_active, 8'hFF);
    sendv('{8'h45, 8'h64});
    settle();
    chk("steal2 freq1", frequencies[1], 450560);
    // pedal: only honoured when the sustain feature is built in
    do_reset();
    sendv('{8'hB0, 8'h40, 8'h7F, 8'h90, 8'h45, 8'h64, 8'h80, 8'h45, 8'h00});
    settle();
`ifdef SUSTAIN_PEDAL_EN
    chk("sus held active", voice_active, 8'h01);
    chk("sus held vol0", voice_volumes[0], 51200);
    sendv('{8'hB0, 8'h40, 8'h00});
    settle();
    chk("sus release active", voice_active, 8'h00);
    chk("sus release vol0", voice_volumes[0], 0);
`else
    chk("nosus active", voice_active, 8'h00);
    chk("nosus vol0", voice_volumes[0], 0);
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
